// File: rtl/mux_scan_reg_if.sv
// Channel bus for mux_scan_reg: N packed channel inputs and controls in,
// registered sample with its channel index and valid flag out.
interface mux_scan_reg_if #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 1
);
    localparam int unsigned SW = $clog2(N);

    logic [N*W-1:0] w;
    logic [SW-1:0]  S;
    logic           Mode;
    logic           Load;
    logic           Ready;
    logic [W-1:0]   f;
    logic [SW-1:0]  Ch;
    logic           Valid;

    modport master (
        output w, S, Mode, Load, Ready,
        input  f, Ch, Valid
    );

    modport slave (
        input  w, S, Mode, Load, Ready,
        output f, Ch, Valid
    );
endinterface

// File: rtl/mux_scan_reg.sv
// N-channel mux with a registered output stage: manual capture on Load or
// auto-scan with a dwell counter, holding each sample until Ready.
module mux_scan_reg #(
    parameter int unsigned N     = 8,
    parameter int unsigned W     = 1,
    parameter int unsigned DWELL = 4
) (
    input  logic            Clock,
    input  logic            Resetn,
    mux_scan_reg_if.slave   bus
);
    localparam int unsigned SW = $clog2(N);
    localparam int unsigned CW = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OUT  = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   f_q, f_d;
    logic [SW-1:0]  ch_q, ch_d;
    logic [SW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           mode_q;

    logic [SW-1:0]  sel_c;
    logic [CW-1:0]  cnt_eff_c;
    logic [W-1:0]   man_data_c;
    logic [W-1:0]   scan_data_c;

    // Out-of-range selects clamp to the last channel.
    always_comb begin
        sel_c       = bus.S;
        man_data_c  = '0;
        scan_data_c = '0;
        if (32'(bus.S) >= N) begin
            sel_c = SW'(N - 1);
        end
        for (int i = 0; i < N; i++) begin
            if (sel_c == SW'(i)) begin
                man_data_c = bus.w[i*W +: W];
            end
            if (ptr_q == SW'(i)) begin
                scan_data_c = bus.w[i*W +: W];
            end
        end
    end

    // A Mode edge restarts the dwell; the edge cycle itself is dwell cycle 0.
    always_comb begin
        state_d   = state_q;
        f_d       = f_q;
        ch_d      = ch_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        cnt_eff_c = (bus.Mode != mode_q) ? '0 : cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!bus.Mode) begin
                    cnt_d = '0;
                    if (bus.Load) begin
                        f_d     = man_data_c;
                        ch_d    = sel_c;
                        state_d = ST_OUT;
                    end
                end else if (cnt_eff_c == CW'(DWELL - 1)) begin
                    f_d     = scan_data_c;
                    ch_d    = ptr_q;
                    ptr_d   = (ptr_q == SW'(N - 1)) ? '0 : ptr_q + SW'(1);
                    cnt_d   = '0;
                    state_d = ST_OUT;
                end else begin
                    cnt_d = cnt_eff_c + CW'(1);
                end
            end
            ST_OUT: begin
                cnt_d = '0;
                if (bus.Ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
            f_q     <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            mode_q  <= bus.Mode;
        end
    end

    assign bus.f     = f_q;
    assign bus.Ch    = ch_q;
    assign bus.Valid = (state_q == ST_OUT);

endmodule

// File: tb/tb_mux_scan_reg.sv
// Bench for mux_scan_reg: three configurations (8/6/4 channels) with a
// per-instance queue of expected samples compared as Valid pulses appear.
module tb_mux_scan_reg;
    typedef struct packed {
        logic [3:0] ch;
        logic [3:0] f;
    } exp_t;

    logic clk = 1'b0;
    logic rstn_a, rstn_b, rstn_c;
    int   errors = 0;
    int   checks = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t sb_c[$];

    always #5 clk = ~clk;

    mux_scan_reg_if #(.N(8), .W(4)) ia ();
    mux_scan_reg_if #(.N(6), .W(4)) ib ();
    mux_scan_reg_if #(.N(4), .W(4)) ic ();

    mux_scan_reg #(.N(8), .W(4), .DWELL(4)) u_a (.Clock(clk), .Resetn(rstn_a), .bus(ia));
    mux_scan_reg #(.N(6), .W(4), .DWELL(2)) u_b (.Clock(clk), .Resetn(rstn_b), .bus(ib));
    mux_scan_reg #(.N(4), .W(4), .DWELL(3)) u_c (.Clock(clk), .Resetn(rstn_c), .bus(ic));

    function automatic exp_t mk(input int ch, input int f);
        exp_t e;
        e.ch = 4'(ch);
        e.f  = 4'(f);
        return e;
    endfunction

    task automatic test_reset();
        checks++; if (ia.Valid !== 1'b0 || ia.f !== 4'd0 || 4'(ia.Ch) !== 4'd0) begin
            errors++; $display("FAIL reset_a: valid=%b f=%0d ch=%0d expected 0/0/0", ia.Valid, ia.f, ia.Ch); end
        checks++; if (ib.Valid !== 1'b0 || ib.f !== 4'd0 || 4'(ib.Ch) !== 4'd0) begin
            errors++; $display("FAIL reset_b: valid=%b f=%0d ch=%0d expected 0/0/0", ib.Valid, ib.f, ib.Ch); end
        checks++; if (ic.Valid !== 1'b0 || ic.f !== 4'd0 || 4'(ic.Ch) !== 4'd0) begin
            errors++; $display("FAIL reset_c: valid=%b f=%0d ch=%0d expected 0/0/0", ic.Valid, ic.f, ic.Ch); end
    endtask

    task automatic test_manual();
        exp_t e;
        ia.Mode = 1'b0; ia.S = 3'd5; ia.Ready = 1'b0; ia.Load = 1'b1;
        sb_a.push_back(mk(5, 6));
        @(negedge clk);
        ia.Load = 1'b0;
        checks++; if (ia.Valid !== 1'b1) begin
            errors++; $display("FAIL manual_valid: got %b expected 1", ia.Valid); end
        e = sb_a.pop_front();
        checks++; if (ia.f !== e.f || 4'(ia.Ch) !== e.ch) begin
            errors++; $display("FAIL manual_data: f=%0d ch=%0d expected f=%0d ch=%0d", ia.f, ia.Ch, e.f, e.ch); end
        // Disturb inputs while the sample is held.
        ia.w[5*4 +: 4] = 4'hE; ia.S = 3'd2; ia.Load = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (ia.Valid !== 1'b1 || ia.f !== e.f || 4'(ia.Ch) !== e.ch) begin
                errors++; $display("FAIL manual_hold%0d: valid=%b f=%0d ch=%0d expected 1/%0d/%0d",
                                   k, ia.Valid, ia.f, ia.Ch, e.f, e.ch); end
        end
        ia.Load = 1'b0; ia.Ready = 1'b1; ia.w[5*4 +: 4] = 4'd6;
        @(negedge clk);
        checks++; if (ia.Valid !== 1'b0 || ia.f !== 4'd6 || 4'(ia.Ch) !== 4'd5) begin
            errors++; $display("FAIL manual_release: valid=%b f=%0d ch=%0d expected 0/6/5", ia.Valid, ia.f, ia.Ch); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (ia.Valid !== 1'b0) begin
            errors++; $display("FAIL ready_in_idle: valid=%b expected 0", ia.Valid); end
        ia.Ready = 1'b0;
    endtask

    task automatic test_out_of_range();
        exp_t e;
        int sel[4] = '{7, 6, 3, 0};
        for (int k = 0; k < 4; k++) begin
            ib.Mode = 1'b0; ib.S = 3'(sel[k]); ib.Load = 1'b1;
            sb_b.push_back(mk(sel[k] > 5 ? 5 : sel[k], (sel[k] > 5 ? 5 : sel[k]) + 10));
            @(negedge clk);
            ib.Load = 1'b0;
            e = sb_b.pop_front();
            checks++; if (ib.Valid !== 1'b1 || ib.f !== e.f || 4'(ib.Ch) !== e.ch) begin
                errors++; $display("FAIL sel_%0d: valid=%b f=%0d ch=%0d expected 1/%0d/%0d",
                                   sel[k], ib.Valid, ib.f, ib.Ch, e.f, e.ch); end
            ib.Ready = 1'b1;
            @(negedge clk);
            ib.Ready = 1'b0;
            checks++; if (ib.Valid !== 1'b0) begin
                errors++; $display("FAIL sel_%0d_release: valid=%b expected 0", sel[k], ib.Valid); end
        end
    endtask

    task automatic test_scan_nonpow2();
        exp_t e;
        int   got = 0;
        int   n = 0;
        for (int k = 0; k < 7; k++) sb_b.push_back(mk(k % 6, (k % 6) + 10));
        ib.Ready = 1'b1; ib.Mode = 1'b1;
        while (got < 7 && n < 80) begin
            @(negedge clk); n++;
            if (ib.Valid === 1'b1) begin
                e = sb_b.pop_front();
                checks++; if (ib.f !== e.f || 4'(ib.Ch) !== e.ch) begin
                    errors++; $display("FAIL scan6_%0d: f=%0d ch=%0d expected f=%0d ch=%0d", got, ib.f, ib.Ch, e.f, e.ch); end
                got++;
            end
        end
        checks++; if (got != 7) begin
            errors++; $display("FAIL scan6_count: got %0d samples expected 7", got); end
        ib.Mode = 1'b0;
        @(negedge clk);
        ib.Ready = 1'b0;
        sb_b.delete();
    endtask

    task automatic test_scan_wrap();
        exp_t e;
        int   got = 0;
        int   n = 0;
        int   last = 0;
        logic prev = 1'b0;
        for (int k = 0; k < 5; k++) sb_c.push_back(mk(k % 4, 3 * (k % 4) + 1));
        ic.Ready = 1'b1; ic.Mode = 1'b1;
        while (got < 5 && n < 60) begin
            @(negedge clk); n++;
            if (prev) begin
                checks++; if (ic.Valid !== 1'b0) begin
                    errors++; $display("FAIL pulse_width: valid=%b at cycle %0d expected 0", ic.Valid, n); end
            end
            if (ic.Valid === 1'b1) begin
                checks++; if ((got == 0) ? (n != 3) : (n - last != 4)) begin
                    errors++; $display("FAIL pulse_spacing_%0d: cycle %0d last %0d", got, n, last); end
                e = sb_c.pop_front();
                checks++; if (ic.f !== e.f || 4'(ic.Ch) !== e.ch) begin
                    errors++; $display("FAIL scan4_%0d: f=%0d ch=%0d expected f=%0d ch=%0d", got, ic.f, ic.Ch, e.f, e.ch); end
                last = n; got++;
            end
            prev = ic.Valid;
        end
        checks++; if (got != 5) begin
            errors++; $display("FAIL scan4_count: got %0d samples expected 5", got); end
        ic.Mode = 1'b0;
        @(negedge clk);
        ic.Ready = 1'b0;
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   n = 0;
        ic.Ready = 1'b0; ic.Mode = 1'b1;
        sb_c.push_back(mk(1, 4));
        while (ic.Valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++; if (n != 3) begin
            errors++; $display("FAIL bp_first_latency: %0d cycles expected 3", n); end
        e = sb_c.pop_front();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++; if (ic.Valid !== 1'b1 || ic.f !== e.f || 4'(ic.Ch) !== e.ch) begin
                errors++; $display("FAIL bp_hold%0d: valid=%b f=%0d ch=%0d expected 1/%0d/%0d",
                                   k, ic.Valid, ic.f, ic.Ch, e.f, e.ch); end
        end
        ic.Ready = 1'b1;
        sb_c.push_back(mk(2, 7));
        @(negedge clk);
        ic.Ready = 1'b0;
        n = 1;
        checks++; if (ic.Valid !== 1'b0) begin
            errors++; $display("FAIL bp_release: valid=%b expected 0", ic.Valid); end
        while (ic.Valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++; if (n != 4) begin
            errors++; $display("FAIL bp_next_latency: %0d cycles expected 4", n); end
        e = sb_c.pop_front();
        checks++; if (ic.f !== e.f || 4'(ic.Ch) !== e.ch) begin
            errors++; $display("FAIL bp_next_data: f=%0d ch=%0d expected f=%0d ch=%0d", ic.f, ic.Ch, e.f, e.ch); end
        ic.Ready = 1'b1; ic.Mode = 1'b0;
        @(negedge clk);
        ic.Ready = 1'b0;
    endtask

    task automatic test_mode_switch();
        exp_t e;
        int   n = 0;
        int   seen = 0;
        ic.Mode = 1'b1;
        @(negedge clk); seen += int'(ic.Valid);
        @(negedge clk); seen += int'(ic.Valid);
        ic.Mode = 1'b0;
        for (int k = 0; k < 3; k++) begin @(negedge clk); seen += int'(ic.Valid); end
        checks++; if (seen != 0) begin
            errors++; $display("FAIL mode_switch_nocap: %0d valid cycles expected 0", seen); end
        ic.Mode = 1'b1;
        sb_c.push_back(mk(3, 10));
        while (ic.Valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++; if (n != 3) begin
            errors++; $display("FAIL mode_switch_latency: %0d cycles expected 3", n); end
        e = sb_c.pop_front();
        checks++; if (ic.f !== e.f || 4'(ic.Ch) !== e.ch) begin
            errors++; $display("FAIL mode_switch_data: f=%0d ch=%0d expected f=%0d ch=%0d", ic.f, ic.Ch, e.f, e.ch); end
        ic.Ready = 1'b1; ic.Mode = 1'b0;
        @(negedge clk);
        ic.Ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   n;
        ia.Load = 1'b0; ia.Ready = 1'b1; ia.Mode = 1'b1;
        for (int k = 0; k < 3; k++) sb_a.push_back(mk(k, k + 1));
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (ia.Valid !== 1'b1 && n < 30) begin @(negedge clk); n++; end
            e = sb_a.pop_front();
            checks++; if (ia.Valid !== 1'b1 || ia.f !== e.f || 4'(ia.Ch) !== e.ch) begin
                errors++; $display("FAIL pre_reset_scan%0d: valid=%b f=%0d ch=%0d expected 1/%0d/%0d",
                                   k, ia.Valid, ia.f, ia.Ch, e.f, e.ch); end
            if (k < 2) begin
                @(negedge clk);
                if (k == 1) ia.Ready = 1'b0;
            end
        end
        rstn_a = 1'b0; ia.Load = 1'b1; ia.S = 3'd4;
        @(negedge clk);
        rstn_a = 1'b1;
        checks++; if (ia.Valid !== 1'b0 || ia.f !== 4'd0 || 4'(ia.Ch) !== 4'd0) begin
            errors++; $display("FAIL reset_mid: valid=%b f=%0d ch=%0d expected 0/0/0", ia.Valid, ia.f, ia.Ch); end
        sb_a.push_back(mk(0, 1));
        n = 0;
        while (ia.Valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++; if (n != 4) begin
            errors++; $display("FAIL reset_restart_latency: %0d cycles expected 4", n); end
        e = sb_a.pop_front();
        checks++; if (ia.f !== e.f || 4'(ia.Ch) !== e.ch) begin
            errors++; $display("FAIL reset_restart_data: f=%0d ch=%0d expected f=%0d ch=%0d", ia.f, ia.Ch, e.f, e.ch); end
        ia.Load = 1'b0; ia.Ready = 1'b1; ia.Mode = 1'b0;
        @(negedge clk);
        ia.Ready = 1'b0;
    endtask

    initial begin
        rstn_a = 1'b0; rstn_b = 1'b0; rstn_c = 1'b0;
        ia.S = '0; ia.Mode = 1'b0; ia.Load = 1'b0; ia.Ready = 1'b0;
        ib.S = '0; ib.Mode = 1'b0; ib.Load = 1'b0; ib.Ready = 1'b0;
        ic.S = '0; ic.Mode = 1'b0; ic.Load = 1'b0; ic.Ready = 1'b0;
        for (int i = 0; i < 8; i++) ia.w[i*4 +: 4] = 4'(i + 1);
        for (int i = 0; i < 6; i++) ib.w[i*4 +: 4] = 4'(i + 10);
        for (int i = 0; i < 4; i++) ic.w[i*4 +: 4] = 4'(3 * i + 1);
        repeat (3) @(negedge clk);
        test_reset();
        rstn_a = 1'b1; rstn_b = 1'b1; rstn_c = 1'b1;
        @(negedge clk);
        test_manual();
        test_out_of_range();
        test_scan_nonpow2();
        test_scan_wrap();
        test_backpressure();
        test_mode_switch();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mux_scan_reg.md
MUX_SCAN_REG -- requirements
Module: mux_scan_reg

Interface
REQ-001 The block SHALL take parameter N, default 8, meaning number of input channels, legal range 2..16.
REQ-002 The block SHALL take parameter W, default 1, meaning data width per channel in bits.
REQ-003 The block SHALL take parameter DWELL, default 4, meaning idle cycles per scan step, legal range 1..255.
REQ-004 The block SHALL derive localparam SW = clog2(N), the select and channel-index width.
REQ-005 Clock  in  1  sole clock; all state updates on rising edge.
REQ-006 Resetn  in  1  synchronous, active-low reset, sampled on the rising edge of Clock.
REQ-007 w  in  N*W  channel inputs; channel i occupies w[i*W +: W].
REQ-008 S  in  SW  manual channel select.
REQ-009 Mode  in  1  0 = manual, 1 = auto-scan.
REQ-010 Load  in  1  manual capture request; honoured only in IDLE with Mode = 0.
REQ-011 Ready  in  1  downstream accepts the current output.
REQ-012 f  out  W  registered selected data.
REQ-013 Ch  out  SW  index of the channel held in f.
REQ-014 Valid  out  1  f and Ch hold an unaccepted sample.

Function
REQ-015 The block SHALL implement a two-state FSM, IDLE (Valid = 0) and OUT (Valid = 1), with Valid driven from the state register.
REQ-016 In IDLE with Mode = 0 and Load = 1, the block SHALL capture f <= w[S], set Ch <= S, and enter OUT, so Valid rises one cycle after Load.
REQ-017 For any S >= N, the block SHALL select channel N-1, with Ch = N-1.
REQ-018 In IDLE with Mode = 1, the dwell counter SHALL increment each cycle.
REQ-019 When the dwell counter equals DWELL-1, the block SHALL capture f <= w[ptr], set Ch <= ptr, advance ptr (wrapping N-1 -> 0), clear the counter, and enter OUT.
REQ-020 The first scan sample SHALL therefore appear DWELL cycles after IDLE is entered with Mode = 1.
REQ-021 In OUT, f, Ch and Valid SHALL remain stable until Ready = 1 is sampled.
REQ-022 In OUT, the dwell counter SHALL hold at 0, and Load, S and Mode SHALL be ignored.
REQ-023 In OUT with Ready = 1, the block SHALL return to IDLE, with Valid = 0 the next cycle.
REQ-024 After that return, f and Ch SHALL retain their last values.
REQ-025 A new capture SHALL be possible no earlier than the cycle after the return to IDLE, giving a maximum throughput of one sample per 2 cycles.
REQ-026 Ready while in IDLE SHALL have no effect.
REQ-027 A Mode change in IDLE SHALL clear the dwell counter and retain ptr, so scanning resumes at the next unscanned channel.
REQ-028 Load = 1 with Mode = 1 SHALL be ignored.
REQ-029 When N is not a power of two, ptr SHALL never reach a value >= N.
REQ-030 The w inputs SHALL be sampled only in the capture cycle; later changes SHALL not affect f.

Reset
REQ-031 When Resetn = 0 at a rising edge, the block SHALL set state = IDLE, Valid = 0, f = 0, Ch = 0, ptr = 0 and dwell counter = 0.
REQ-032 Reset SHALL take priority over all other inputs.
REQ-033 A reset asserted in OUT SHALL discard the pending sample without a handshake.
REQ-034 In the first cycle after Resetn returns to 1, the block SHALL behave as IDLE.

Verification
REQ-035 The bench SHALL cover manual capture: N=8, W=4, w[i]=i+1, Mode=0, S=5, Load pulse -> next cycle Valid=1, f=6, Ch=5; hold Ready=0 for 3 cycles -> outputs stable; Ready=1 -> Valid=0 the next cycle.
REQ-036 The bench SHALL cover out-of-range select: N=6, S=7, Load -> f=w[5], Ch=5.
REQ-037 The bench SHALL cover the scan sequence with wrap: N=4, DWELL=3, Mode=1, Ready tied to 1 -> Ch sequence 0,1,2,3,0, with each Valid pulse one cycle wide and pulses 4 cycles apart.
REQ-038 The bench SHALL cover backpressure in scan: Ready held at 0 for 10 cycles in OUT -> no ptr advance; after Ready=1, the next sample arrives DWELL cycles after the return to IDLE.
REQ-039 The bench SHALL cover a mode switch mid-dwell: Mode=1 for DWELL-1 cycles, then Mode=0 -> no capture; Mode=1 again -> capture after a full DWELL, with ptr unchanged.
REQ-040 The bench SHALL cover reset mid-operation: Resetn=0 for one cycle while Valid=1 -> next cycle Valid=0, f=0, Ch=0; scan restarts at channel 0.
